// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory handshake and fills the IF/ID register.
// Latency: one instruction per cycle with zero-wait memory; IF/ID is loaded on the edge that carries the ack.
// Backpressure: stall_i freezes IF/ID, and a word that arrives during a stall waits in a one-entry hold buffer.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   stall_i                      decode hazard stall, IF/ID holds
//   if_flush_i, pc_branch_i      taken branch redirect and its target
//   jmp_i, pc_jmp_i              JAL redirect and its target (wins over branch)
//   imem_req_o, imem_addr_o      fetch request and address
//   imem_ack_i, imem_rdata_i     one-cycle completion pulse and the instruction word
//   pc_o, inst_o, valid_o        IF/ID register towards decode
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        if_flush_i,
    input  logic [31:0] pc_branch_i,
    input  logic        jmp_i,
    input  logic [31:0] pc_jmp_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_KILL = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt;
    // Address of the request currently on the bus; S_KILL keeps presenting it
    // until the memory answers, even though pc_r has already moved to the target.
    logic [31:0] addr_r;
    logic [31:0] buf_pc;
    logic [31:0] buf_inst;

    logic        redirect;
    logic [31:0] target;
    logic        buf_ld;
    logic        new_vld;
    logic [31:0] new_pc;
    logic [31:0] new_inst;

    assign redirect = jmp_i | if_flush_i;
    assign target   = jmp_i ? pc_jmp_i : pc_branch_i;

    // ------------------------------------------------------------------
    // State, PC, in-flight address and hold buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc_r     <= RESET_PC;
            addr_r   <= RESET_PC;
            buf_pc   <= 32'h0000_0000;
            buf_inst <= 32'h0000_0000;
        end else begin
            state <= state_nxt;
            pc_r  <= pc_nxt;
            if (state == S_REQ) begin
                addr_r <= pc_r;
            end
            if (buf_ld) begin
                buf_pc   <= pc_r;
                buf_inst <= imem_rdata_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state, next PC, memory request and the candidate IF/ID word
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_r;
        buf_ld      = 1'b0;
        new_vld     = 1'b0;
        new_pc      = buf_pc;
        new_inst    = buf_inst;
        imem_req_o  = 1'b0;
        imem_addr_o = pc_r;

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                if (redirect) begin
                    pc_nxt = target;
                end
            end

            S_REQ: begin
                imem_req_o  = 1'b1;
                imem_addr_o = pc_r;
                if (imem_ack_i) begin
                    if (redirect) begin
                        // Word belongs to the wrong path: drop it.
                        pc_nxt = target;
                    end else begin
                        pc_nxt = pc_r + 32'd4;
                        if (stall_i) begin
                            buf_ld    = 1'b1;
                            state_nxt = S_HOLD;
                        end else begin
                            new_vld  = 1'b1;
                            new_pc   = pc_r;
                            new_inst = imem_rdata_i;
                        end
                    end
                end else if (redirect) begin
                    // Cannot retract the address mid-request; let it drain in S_KILL.
                    pc_nxt    = target;
                    state_nxt = S_KILL;
                end
            end

            S_KILL: begin
                imem_req_o  = 1'b1;
                imem_addr_o = addr_r;
                if (redirect) begin
                    pc_nxt = target;
                end
                if (imem_ack_i) begin
                    state_nxt = S_REQ;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = S_REQ;
                end else if (!stall_i) begin
                    new_vld   = 1'b1;
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // IF/ID register: a redirect bubbles it even while decode is stalled,
    // because the instruction it holds is on the squashed path.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_o    <= 32'h0000_0000;
            inst_o  <= NOP_INST;
            valid_o <= 1'b0;
        end else if (redirect) begin
            inst_o  <= NOP_INST;
            valid_o <= 1'b0;
        end else if (stall_i) begin
            pc_o    <= pc_o;
            inst_o  <= inst_o;
            valid_o <= valid_o;
        end else if (new_vld) begin
            pc_o    <= new_pc;
            inst_o  <= new_inst;
            valid_o <= 1'b1;
        end else begin
            inst_o  <= NOP_INST;
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        if_flush_i;
    logic [31:0] pc_branch_i;
    logic        jmp_i;
    logic [31:0] pc_jmp_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .if_flush_i   (if_flush_i),
        .pc_branch_i  (pc_branch_i),
        .jmp_i        (jmp_i),
        .pc_jmp_i     (pc_jmp_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .valid_o      (valid_o)
    );

    int checks     = 0;
    int failures   = 0;
    int deliveries = 0;

    // Scoreboard: redirect targets pushed by the stimulus; the first delivered
    // instruction after a redirect must come from the newest target.
    logic [31:0] tgt_q[$];

    int mem_lat  = 0;   // fixed latency, or random 0..3 when negative
    bit spur_en  = 1'b0;
    int mem_wait = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_0100;
    endfunction

    function automatic int pick_lat();
        if (mem_lat < 0) return int'($urandom_range(0, 3));
        return mem_lat;
    endfunction

    task automatic set_redir(input bit j, input bit f, input logic [31:0] pj, input logic [31:0] pb);
        jmp_i       = j;
        if_flush_i  = f;
        pc_jmp_i    = pj;
        pc_branch_i = pb;
        if (j || f) begin
            tgt_q.delete();
            tgt_q.push_back(j ? pj : pb);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_req",   {31'b0, imem_req_o}, 32'd0);
        chk("rst_addr",  imem_addr_o, RESET_PC);
        chk("rst_pc",    pc_o, 32'd0);
        chk("rst_inst",  inst_o, NOP);
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        tgt_q.delete();
        tgt_q.push_back(RESET_PC);
        repeat (cycles) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    // Memory responder: acks after mem_wait cycles of request, same cycle when zero.
    initial begin
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                imem_ack_i = 1'b0;
                mem_wait   = pick_lat();
            end else if (imem_req_o) begin
                if (mem_wait == 0) begin
                    imem_ack_i   = 1'b1;
                    imem_rdata_i = mem_word(imem_addr_o);
                    mem_wait     = pick_lat();
                end else begin
                    imem_ack_i   = 1'b0;
                    imem_rdata_i = 32'hDEAD_BEEF;
                    mem_wait--;
                end
            end else begin
                imem_ack_i   = spur_en && ($urandom_range(0, 7) == 0);
                imem_rdata_i = $urandom;
            end
        end
    end

    // Monitor: checks IF/ID against the rules for every clock edge.
    initial begin
        logic [31:0] pv_pc, pv_inst, pv_addr, exp_next, e_pc;
        logic        pv_valid, pv_req, e_stall, e_redir, e_ack, e_rst;
        pv_pc = 0; pv_inst = NOP; pv_addr = RESET_PC; exp_next = RESET_PC;
        pv_valid = 0; pv_req = 0;
        forever begin
            @(posedge clk);
            e_stall = stall_i;
            e_redir = jmp_i | if_flush_i;
            e_ack   = imem_ack_i;
            e_rst   = rst;
            #1;
            if (!e_rst || !rst) begin
                pv_pc = 0; pv_inst = NOP; pv_valid = 0; pv_req = 0;
                pv_addr = RESET_PC; exp_next = RESET_PC;
            end else begin
                if (pv_req && !e_ack) begin
                    chk("req_held", {31'b0, imem_req_o}, 32'd1);
                    chk("addr_held", imem_addr_o, pv_addr);
                end
                if (e_redir) begin
                    chk("redir_valid", {31'b0, valid_o}, 32'd0);
                    chk("redir_inst", inst_o, NOP);
                    chk("redir_pc", pc_o, pv_pc);
                end else if (e_stall) begin
                    chk("stall_pc", pc_o, pv_pc);
                    chk("stall_inst", inst_o, pv_inst);
                    chk("stall_valid", {31'b0, valid_o}, {31'b0, pv_valid});
                end else if (valid_o) begin
                    e_pc = (tgt_q.size() > 0) ? tgt_q.pop_front() : exp_next;
                    chk("deliv_pc", pc_o, e_pc);
                    chk("deliv_inst", inst_o, mem_word(e_pc));
                    exp_next = e_pc + 32'd4;
                    deliveries++;
                end else begin
                    chk("bubble_inst", inst_o, NOP);
                end
                pv_pc = pc_o; pv_inst = inst_o; pv_valid = valid_o;
                pv_req = imem_req_o; pv_addr = imem_addr_o;
            end
        end
    end

    // Stimulus
    initial begin
        int stall_left;
        rst = 1'b0;
        stall_i = 1'b0;
        set_redir(1'b0, 1'b0, 32'h0, 32'h0);
        mem_lat = 0;

        // Zero-wait streaming from reset.
        do_reset(2);
        @(negedge clk);
        chk("d1_req", {31'b0, imem_req_o}, 32'd1);
        chk("d1_addr0", imem_addr_o, 32'h0);
        @(negedge clk);
        chk("d1_addr4", imem_addr_o, 32'h4);
        chk("d1_pc0", pc_o, 32'h0);
        chk("d1_inst0", inst_o, 32'h100);
        chk("d1_valid", {31'b0, valid_o}, 32'd1);
        @(negedge clk);
        chk("d1_addr8", imem_addr_o, 32'h8);
        chk("d1_pc4", pc_o, 32'h4);
        chk("d1_inst4", inst_o, 32'h104);

        // Stall for 3 cycles over the ack of 0xC.
        @(negedge clk);
        chk("st_addrC", imem_addr_o, 32'hC);
        mem_lat = 3;
        stall_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("st_req_off", {31'b0, imem_req_o}, 32'd0);
            chk("st_pc_held", pc_o, 32'h8);
        end
        stall_i = 1'b0;
        @(negedge clk);
        chk("st_pcC", pc_o, 32'hC);
        chk("st_next_addr", imem_addr_o, 32'h10);

        // Branch flush while 0x10 is pending with latency 3.
        set_redir(1'b0, 1'b1, 32'h0, 32'h40);
        @(negedge clk);
        set_redir(1'b0, 1'b0, 32'h0, 32'h0);
        mem_lat = 0;
        chk("fl_addr_a", imem_addr_o, 32'h10);
        chk("fl_valid", {31'b0, valid_o}, 32'd0);
        chk("fl_inst", inst_o, NOP);
        @(negedge clk);
        chk("fl_addr_b", imem_addr_o, 32'h10);
        @(negedge clk);
        chk("fl_addr_c", imem_addr_o, 32'h10);
        @(negedge clk);
        chk("fl_addr_tgt", imem_addr_o, 32'h40);
        chk("fl_req", {31'b0, imem_req_o}, 32'd1);

        // Jump and branch together: the jump wins.
        set_redir(1'b1, 1'b1, 32'h80, 32'h40);
        @(negedge clk);
        chk("jb_addr", imem_addr_o, 32'h80);

        // PC wrap at the top of the address space.
        set_redir(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
        @(negedge clk);
        set_redir(1'b0, 1'b0, 32'h0, 32'h0);
        chk("wr_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wr_addr_zero", imem_addr_o, 32'h0);
        chk("wr_pc_top", pc_o, 32'hFFFF_FFFC);
        mem_lat = 5;
        @(negedge clk);
        chk("mr_pending", imem_addr_o, 32'h4);

        // Reset in the middle of an outstanding request.
        do_reset(2);

        // Randomized traffic.
        mem_lat = -1;
        spur_en = 1'b1;
        stall_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc == 2000) begin
                stall_i = 1'b0;
                set_redir(1'b0, 1'b0, 32'h0, 32'h0);
                do_reset(3);
                continue;
            end
            if (stall_left > 0) begin
                stall_i = 1'b1;
                stall_left--;
            end else if ($urandom_range(0, 7) == 0) begin
                stall_i = 1'b1;
                stall_left = int'($urandom_range(0, 3));
            end else begin
                stall_i = 1'b0;
            end
            begin
                logic [31:0] pj, pb;
                int r;
                pj = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                pb = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                if ($urandom_range(0, 9) == 0) pj = 32'hFFFF_FFF8;
                r = int'($urandom_range(0, 15));
                case (r)
                    0:       set_redir(1'b1, 1'b0, pj, pb);
                    1:       set_redir(1'b0, 1'b1, pj, pb);
                    2:       set_redir(1'b1, 1'b1, pj, pb);
                    default: set_redir(1'b0, 1'b0, pj, pb);
                endcase
            end
        end
        stall_i = 1'b0;
        set_redir(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (10) @(negedge clk);
        chk("progress", {31'b0, deliveries > 200}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
